// File: rtl/titan_ex_stage_md.sv
// Titan execute stage: single-cycle ALU, iterative RV32M/RV64M multiply/divide
// unit and the EX/MEM pipeline register with an opaque sideband bundle.
module titan_ex_stage_md #(
  parameter int XLEN   = 32,
  parameter int SIDE_W = 64,
  parameter int CNT_W  = $clog2(XLEN) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_stall_i,
  input  logic              mem_flush_i,
  input  logic              ex_valid_i,
  input  logic [XLEN-1:0]   ex_pc_i,
  input  logic [31:0]       ex_instruction_i,
  input  logic [XLEN-1:0]   ex_port_a_i,
  input  logic [XLEN-1:0]   ex_port_b_i,
  input  logic [3:0]        ex_alu_op_i,
  input  logic              ex_md_en_i,
  input  logic [2:0]        ex_md_op_i,
  input  logic [XLEN-1:0]   ex_store_data_i,
  input  logic [4:0]        ex_waddr_i,
  input  logic              ex_we_i,
  input  logic [SIDE_W-1:0] ex_side_i,
  output logic              ex_stall_o,
  output logic [XLEN-1:0]   ex_fwd_dat_o,
  output logic              mem_valid_o,
  output logic [XLEN-1:0]   mem_pc_o,
  output logic [31:0]       mem_instruction_o,
  output logic [XLEN-1:0]   mem_result_o,
  output logic [XLEN-1:0]   mem_store_data_o,
  output logic [4:0]        mem_waddr_o,
  output logic              mem_we_o,
  output logic [SIDE_W-1:0] mem_side_o
);

  localparam int SH_W = $clog2(XLEN);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  localparam logic [XLEN-1:0] ZERO_X  = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_X  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  // ---------------------------------------------------------------- ALU
  logic [XLEN-1:0] alu_res_s;
  logic [SH_W-1:0] shamt_s;

  assign shamt_s = ex_port_b_i[SH_W-1:0];

  always_comb begin
    alu_res_s = ex_port_b_i;
    case (ex_alu_op_i)
      ALU_ADD:  alu_res_s = ex_port_a_i + ex_port_b_i;
      ALU_SUB:  alu_res_s = ex_port_a_i - ex_port_b_i;
      ALU_SLL:  alu_res_s = ex_port_a_i << shamt_s;
      ALU_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(ex_port_a_i) < $signed(ex_port_b_i))};
      ALU_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (ex_port_a_i < ex_port_b_i)};
      ALU_XOR:  alu_res_s = ex_port_a_i ^ ex_port_b_i;
      ALU_SRL:  alu_res_s = ex_port_a_i >> shamt_s;
      ALU_SRA:  alu_res_s = $signed(ex_port_a_i) >>> shamt_s;
      ALU_OR:   alu_res_s = ex_port_a_i | ex_port_b_i;
      ALU_AND:  alu_res_s = ex_port_a_i & ex_port_b_i;
      default:  alu_res_s = ex_port_b_i;
    endcase
  end

  // ------------------------------------------------ M-op operand decode
  logic            is_div_s, a_sgn_s, b_sgn_s, a_neg_s, b_neg_s;
  logic            div_zero_s, div_ovf_s, res_neg_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s, special_res_s;

  assign is_div_s = ex_md_op_i[2];
  assign a_sgn_s  = (ex_md_op_i == MD_MULH) | (ex_md_op_i == MD_MULHSU) |
                    (ex_md_op_i == MD_DIV)  | (ex_md_op_i == MD_REM);
  assign b_sgn_s  = (ex_md_op_i == MD_MULH) | (ex_md_op_i == MD_DIV) |
                    (ex_md_op_i == MD_REM);
  assign a_neg_s  = a_sgn_s & ex_port_a_i[XLEN-1];
  assign b_neg_s  = b_sgn_s & ex_port_b_i[XLEN-1];
  assign a_mag_s  = a_neg_s ? (ZERO_X - ex_port_a_i) : ex_port_a_i;
  assign b_mag_s  = b_neg_s ? (ZERO_X - ex_port_b_i) : ex_port_b_i;

  assign div_zero_s = is_div_s & (ex_port_b_i == ZERO_X);
  assign div_ovf_s  = is_div_s & b_sgn_s & (ex_port_a_i == MIN_INT) &
                      (ex_port_b_i == ONES_X);
  // Bit 1 of funct3 selects remainder among the divide ops.
  assign special_res_s = div_zero_s ? (ex_md_op_i[1] ? ex_port_a_i : ONES_X)
                                    : (ex_md_op_i[1] ? ZERO_X : ex_port_a_i);
  assign res_neg_s = (is_div_s & ex_md_op_i[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);

  // ------------------------------------------------ iterative datapath
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, opb_q, opb_d, res_q, res_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;

  logic [XLEN:0]     mul_sum_s, div_shift_s;
  logic              div_ge_s;
  logic [XLEN-1:0]   step_hi_s, step_lo_s, quo_fix_s, rem_fix_s, final_res_s;
  logic [2*XLEN-1:0] prod_s, prod_fix_s;

  assign mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
  assign div_shift_s = {hi_q, lo_q[XLEN-1]};
  assign div_ge_s    = (div_shift_s >= {1'b0, opb_q});

  always_comb begin
    if (op_q[2]) begin
      step_hi_s = div_ge_s ? (div_shift_s[XLEN-1:0] - opb_q) : div_shift_s[XLEN-1:0];
      step_lo_s = {lo_q[XLEN-2:0], div_ge_s};
    end else begin
      step_hi_s = mul_sum_s[XLEN:1];
      step_lo_s = {mul_sum_s[0], lo_q[XLEN-1:1]};
    end
  end

  assign prod_s     = {step_hi_s, step_lo_s};
  assign prod_fix_s = neg_q ? ({(2*XLEN){1'b0}} - prod_s) : prod_s;
  assign quo_fix_s  = neg_q ? (ZERO_X - step_lo_s) : step_lo_s;
  assign rem_fix_s  = neg_q ? (ZERO_X - step_hi_s) : step_hi_s;

  always_comb begin
    final_res_s = ZERO_X;
    case (op_q)
      MD_MUL:                        final_res_s = prod_fix_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  final_res_s = prod_fix_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               final_res_s = quo_fix_s;
      MD_REM, MD_REMU:               final_res_s = rem_fix_s;
      default:                       final_res_s = ZERO_X;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    op_d    = op_q;
    neg_d   = neg_q;
    res_d   = res_q;
    if (mem_flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = {CNT_W{1'b0}};
      res_d   = ZERO_X;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ex_valid_i & ex_md_en_i) begin
            op_d  = ex_md_op_i;
            neg_d = res_neg_s;
            hi_d  = ZERO_X;
            lo_d  = a_mag_s;
            opb_d = b_mag_s;
            if (div_zero_s | div_ovf_s) begin
              res_d   = special_res_s;
              cnt_d   = {CNT_W{1'b0}};
              state_d = ST_DONE;
            end else begin
              cnt_d   = CNT_W'(XLEN);
              state_d = ST_BUSY;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSY: begin
          hi_d  = step_hi_s;
          lo_d  = step_lo_s;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            res_d   = final_res_s;
            state_d = ST_DONE;
          end else begin
            state_d = ST_BUSY;
          end
        end
        ST_DONE: begin
          if (!mem_stall_i) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      hi_q    <= ZERO_X;
      lo_q    <= ZERO_X;
      opb_q   <= ZERO_X;
      op_q    <= 3'd0;
      neg_q   <= 1'b0;
      res_q   <= ZERO_X;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  logic ex_stall_s;
  assign ex_stall_s   = ex_valid_i & ex_md_en_i & (state_q != ST_DONE) & ~mem_flush_i;
  assign ex_stall_o   = ex_stall_s;
  assign ex_fwd_dat_o = (state_q == ST_DONE) ? res_q : alu_res_s;

  // ------------------------------------------------ EX/MEM register
  logic              mem_valid_q, mem_valid_d, mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_pc_q, mem_pc_d, mem_result_q, mem_result_d;
  logic [XLEN-1:0]   mem_store_q, mem_store_d;
  logic [31:0]       mem_instr_q, mem_instr_d;
  logic [4:0]        mem_waddr_q, mem_waddr_d;
  logic [SIDE_W-1:0] mem_side_q, mem_side_d;

  always_comb begin
    mem_valid_d  = mem_valid_q;
    mem_we_d     = mem_we_q;
    mem_pc_d     = mem_pc_q;
    mem_result_d = mem_result_q;
    mem_store_d  = mem_store_q;
    mem_instr_d  = mem_instr_q;
    mem_waddr_d  = mem_waddr_q;
    mem_side_d   = mem_side_q;
    if (mem_flush_i || (!mem_stall_i && ex_stall_s)) begin
      mem_valid_d  = 1'b0;
      mem_we_d     = 1'b0;
      mem_pc_d     = ZERO_X;
      mem_result_d = ZERO_X;
      mem_store_d  = ZERO_X;
      mem_instr_d  = 32'd0;
      mem_waddr_d  = 5'd0;
      mem_side_d   = {SIDE_W{1'b0}};
    end else if (mem_stall_i) begin
      mem_valid_d  = mem_valid_q;
    end else begin
      // An invalid slot is a bubble and must never write the register file.
      mem_valid_d  = ex_valid_i;
      mem_we_d     = ex_we_i & ex_valid_i;
      mem_pc_d     = ex_pc_i;
      mem_result_d = ex_fwd_dat_o;
      mem_store_d  = ex_store_data_i;
      mem_instr_d  = ex_instruction_i;
      mem_waddr_d  = ex_waddr_i;
      mem_side_d   = ex_side_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_pc_q     <= ZERO_X;
      mem_result_q <= ZERO_X;
      mem_store_q  <= ZERO_X;
      mem_instr_q  <= 32'd0;
      mem_waddr_q  <= 5'd0;
      mem_side_q   <= {SIDE_W{1'b0}};
    end else begin
      mem_valid_q  <= mem_valid_d;
      mem_we_q     <= mem_we_d;
      mem_pc_q     <= mem_pc_d;
      mem_result_q <= mem_result_d;
      mem_store_q  <= mem_store_d;
      mem_instr_q  <= mem_instr_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_side_q   <= mem_side_d;
    end
  end

  assign mem_valid_o       = mem_valid_q;
  assign mem_we_o          = mem_we_q;
  assign mem_pc_o          = mem_pc_q;
  assign mem_result_o      = mem_result_q;
  assign mem_store_data_o  = mem_store_q;
  assign mem_instruction_o = mem_instr_q;
  assign mem_waddr_o       = mem_waddr_q;
  assign mem_side_o        = mem_side_q;

endmodule

// File: doc/titan_ex_stage_md.md
Name: titan_ex_stage_md

Overview:
- Parametrised next-generation execute stage for the Titan pipeline.
- Contains the single-cycle ALU (titan_exu), a new iterative RV32M/RV64M multiply/divide unit, and a built-in EX/MEM pipeline register.
- Stalls the front end while a multi-cycle op runs and forwards the EX result to the hazard unit.
- Carries a generic sideband bundle, so mem flags, CSR fields and exception bits pass through without port edits.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- SIDE_W, 64, width of the opaque sideband carried EX->MEM (mem flags, CSR data/op/addr, exception bits, rs1).
- CNT_W, $clog2(XLEN)+1, width of the iteration counter; derived, do not override.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- mem_stall_i  in  1  hold the EX/MEM register
- mem_flush_i  in  1  squash the EX/MEM register and abort any multi-cycle op
- ex_valid_i  in  1  EX holds a real instruction
- ex_pc_i  in  XLEN  instruction PC
- ex_instruction_i  in  32  instruction word
- ex_port_a_i  in  XLEN  operand A
- ex_port_b_i  in  XLEN  operand B
- ex_alu_op_i  in  4  ALU op code, same encoding as titan_exu
- ex_md_en_i  in  1  instruction is an M-extension op
- ex_md_op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- ex_store_data_i  in  XLEN  store data
- ex_waddr_i  in  5  destination register
- ex_we_i  in  1  register write enable
- ex_side_i  in  SIDE_W  sideband
- ex_stall_o  out  1  EX busy; upstream must hold
- ex_fwd_dat_o  out  XLEN  forwarding data (ALU result, or M result when in DONE)
- mem_valid_o  out  1  registered valid
- mem_pc_o  out  XLEN  registered PC
- mem_instruction_o  out  32  registered instruction
- mem_result_o  out  XLEN  registered result
- mem_store_data_o  out  XLEN  registered store data
- mem_waddr_o  out  5  registered destination register
- mem_we_o  out  1  registered write enable
- mem_side_o  out  SIDE_W  registered sideband

Behaviour:
- Reset: every mem_* output is 0 and the FSM is in IDLE. ex_stall_o is therefore 0 after reset.
- Non-M ops (ex_md_en_i=0): result is the combinational ALU output. EX/MEM latency is 1 cycle and ex_stall_o=0.
- ex_stall_o = ex_valid_i & ex_md_en_i & (state != DONE) & !mem_flush_i.
- FSM states: IDLE, BUSY, DONE.
- IDLE->BUSY: when ex_valid_i & ex_md_en_i & !mem_flush_i. Operands are latched, converted to magnitudes per signedness, and the counter is loaded with XLEN.
- IDLE->DONE (special divide cases, no BUSY cycles):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (min_int / -1): quotient = dividend; remainder = 0.
- BUSY: one shift-add (multiply) or one restoring subtract (divide) per cycle. Counter decrements; when it reaches 1, go to DONE.
- Normal M op timing:
  - ex_stall_o is high for XLEN+1 cycles.
  - DONE occupies 1 cycle; the result is loaded into EX/MEM at the end of DONE if !mem_stall_i.
- Special cases: ex_stall_o is high for 1 cycle.
- Result selection:
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits of the 2·XLEN product.
  - Signed results are negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- DONE->IDLE: when !mem_stall_i. While mem_stall_i is high, the FSM stays in DONE and the result is held.
- mem_flush_i in any state: FSM goes to IDLE, the counter is cleared, and the partial result is discarded.
- EX/MEM register update, in priority order:
  1. rst_i: clear everything.
  2. mem_flush_i: clear mem_valid_o and mem_we_o; other fields go to 0.
  3. mem_stall_i: hold all fields.
  4. ex_stall_o: load a bubble (mem_valid_o=0, mem_we_o=0).
  5. Otherwise: load the EX fields.
- A bubble must never carry mem_we_o=1.
- A new M op issued in the cycle right after DONE->IDLE starts normally; there is no dead cycle.
- Reset asserted mid-BUSY: IDLE on the next edge; no stale result may appear later.
- For XLEN=64, the *W variants are not supported; the decoder must not assert ex_md_en_i for them.

Test Plan:
- ALU add, a=5, b=7, XLEN=32 -> next cycle mem_result_o=12, mem_we_o=1, mem_valid_o=1; ex_stall_o never high.
- MUL a=7, b=0xFFFFFFFD -> ex_stall_o high for exactly 33 cycles, then mem_result_o=0xFFFFFFEB. MULHU 0x80000000×0x80000000 -> 0x40000000.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV by 0 with a=0x1234 -> quotient 0xFFFFFFFF and REM 0x1234, each with a 1-cycle stall. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- DIV in BUSY, mem_flush_i pulsed at cycle 10 -> ex_stall_o drops that cycle, mem_we_o=0, FSM in IDLE. The next ADD completes normally.
- MUL reaching DONE with mem_stall_i held for 3 cycles -> mem_* frozen, FSM stays in DONE, ex_fwd_dat_o stable. On release, the result loads in 1 cycle.
